// File: rtl/mem_responder.sv
// Word-addressed backing store behind request/response valid-ready handshakes; MEM_ADDR_CHK_EN enables address-error checking.
// Latency: resp_valid rises LATENCY cycles after the request is accepted.
// Backpressure: one outstanding request; response and data are held until resp_ready.
module mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              wr;
      logic              err;
      logic [ADDR_W-1:0] idx;
      logic [31:0]       wdata;
   } req_t;

   state_t      state, state_nxt;
   req_t        pend;
   logic [7:0]  cnt;
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] rdata_q;
   logic        err_q;
   logic        req_err;
   logic        accept;
   logic        do_access;

`ifdef MEM_ADDR_CHK_EN
   assign req_err  = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);
   assign resp_err = err_q;
`else
   // Without checking, low and high address bits alias modulo the depth.
   logic unused_addr;
   assign unused_addr = ^{req_addr[1:0], req_addr[31:ADDR_W+2], err_q};
   assign req_err     = 1'b0;
   assign resp_err    = 1'b0;
`endif

   assign accept     = req_valid && req_ready;
   assign do_access  = (state == WAIT) && (cnt == 8'd0);
   assign resp_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = WAIT;
         WAIT:    if (cnt == 8'd0) state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE) && rst_n;
      resp_valid = (state == RESP);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         pend <= '{wr: req_wr, err: req_err, idx: req_addr[ADDR_W+1:2], wdata: req_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= 8'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= 8'(LATENCY - 1);
         end else if ((state == WAIT) && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
         end
         if (do_access) begin
            err_q <= pend.err;
            if (pend.err)     rdata_q <= 32'd0;
            else if (pend.wr) rdata_q <= pend.wdata;
            else              rdata_q <= mem[pend.idx];
         end
      end
   end

   // Storage is never cleared; a reset before the access edge cancels the write.
   always_ff @(posedge clk) begin
      if (rst_n && do_access && pend.wr && !pend.err) begin
         mem[pend.idx] <= pend.wdata;
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level reference model plus directed literal checks.
module tb_mem_responder;
   localparam int ADDR_W = 8;
   localparam int LAT    = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_ready, req_wr;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        u1_req_valid, u1_req_ready, u1_req_wr;
   logic [31:0] u1_req_addr, u1_req_wdata;
   logic        u1_resp_valid, u1_resp_ready, u1_resp_err;
   logic [31:0] u1_resp_rdata;

   int vectors     = 0;
   int miscompares = 0;
   bit chk         = 1'b0;

   mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(u1_req_valid), .req_ready(u1_req_ready), .req_wr(u1_req_wr),
      .req_addr(u1_req_addr), .req_wdata(u1_req_wdata),
      .resp_valid(u1_resp_valid), .resp_ready(u1_resp_ready),
      .resp_rdata(u1_resp_rdata), .resp_err(u1_resp_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction tracked by its age since accept.
   logic [31:0] ref_mem [0:DEPTH-1];
   bit          m_busy = 1'b0;
   int          m_age  = 0;
   bit          m_wr;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata = 32'd0;
   bit          m_err   = 1'b0;
   int          m_idx;

   function automatic bit addr_bad(input logic [31:0] a);
`ifdef MEM_ADDR_CHK_EN
      return ((a % 32'd4) != 32'd0) || ((a / 32'(4 * DEPTH)) != 32'd0);
`else
      return (a === 32'hxxxx_xxxx);
`endif
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_age = 0; m_rdata = 32'd0; m_err = 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy = 1'b1; m_age = 0;
            m_wr = req_wr; m_addr = req_addr; m_wdata = req_wdata;
         end
      end else if (m_age < LAT) begin
         m_age++;
         if (m_age == LAT) begin
            m_idx = int'((m_addr / 32'd4) % 32'(DEPTH));
            if (addr_bad(m_addr)) begin
               m_rdata = 32'd0; m_err = 1'b1;
            end else begin
               m_err = 1'b0;
               if (m_wr) begin
                  ref_mem[m_idx] = m_wdata;
                  m_rdata = m_wdata;
               end else begin
                  m_rdata = ref_mem[m_idx];
               end
            end
         end
      end else if (resp_ready) begin
         m_busy = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk) begin
         check("req_ready", {31'd0, req_ready}, {31'd0, rst_n && !m_busy});
         check("resp_valid", {31'd0, resp_valid}, {31'd0, m_busy && (m_age == LAT)});
         if (m_busy && (m_age == LAT)) begin
            check("resp_rdata", resp_rdata, m_rdata);
            check("resp_err", {31'd0, resp_err}, {31'd0, m_err});
         end
      end
   end

   task automatic wait_valid(output int n);
      n = 0;
      while (!resp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid) check("resp_valid_timeout", {31'd0, resp_valid}, 32'd1);
   endtask

   // Issue one request from a negedge, hold the response 'hold' cycles, return at a negedge.
   task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rd, output logic er, output int lat);
      int n;
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'($urandom_range(0, 1));
      req_wr     = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      resp_ready = 1'($urandom);
      wait_valid(lat);
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      repeat (hold) @(negedge clk);
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_after_handshake", {31'd0, req_ready}, 32'd1);
      check("valid_pulse_end", {31'd0, resp_valid}, 32'd0);
      resp_ready = 1'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;
      logic [31:0] a;

      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      resp_ready = 1'b0;
      u1_req_valid = 1'b0; u1_req_wr = 1'b0; u1_req_addr = 32'd0; u1_req_wdata = 32'd0;
      u1_resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk = 1'b1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("release_req_ready", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 0, rd, er, lat);

      xact(1'b1, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
      check("write_latency", 32'(lat), 32'd4);
      check("write_echo", rd, 32'hDEAD_BEEF);
      xact(1'b0, 32'h10, 32'd0, 0, rd, er, lat);
      check("read_back", rd, 32'hDEAD_BEEF);
      check("read_latency", 32'(lat), 32'd4);

      xact(1'b0, 32'h10, 32'd0, 6, rd, er, lat);
      check("backpressure_data", rd, 32'hDEAD_BEEF);

      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h14; req_wdata = 32'h0000_1111;
      resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h30; req_wdata = 32'hBAD0_0BAD;
      check("busy_req_ready", {31'd0, req_ready}, 32'd0);
      wait_valid(lat);
      check("busy_first_data", resp_rdata, 32'h0000_1111);
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("busy_second_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; resp_ready = 1'b0;
      check("busy_second_taken", {31'd0, req_ready}, 32'd0);
      wait_valid(lat);
      check("busy_second_data", resp_rdata, 32'hBAD0_0BAD);
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      xact(1'b0, 32'h30, 32'd0, 0, rd, er, lat);
      check("busy_mem_30", rd, 32'hBAD0_0BAD);
      xact(1'b0, 32'h14, 32'd0, 0, rd, er, lat);
      check("busy_mem_14", rd, 32'h0000_1111);

      xact(1'b1, 32'h20, 32'h1111_1111, 0, rd, er, lat);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst_rdata", resp_rdata, 32'd0);
      repeat (LAT + 2) @(negedge clk);
      check("midrst_no_late_resp", {31'd0, resp_valid}, 32'd0);
      xact(1'b0, 32'h20, 32'd0, 0, rd, er, lat);
      check("midrst_mem_kept", rd, 32'h1111_1111);

`ifdef MEM_ADDR_CHK_EN
      xact(1'b1, 32'h0, 32'h0BAD_F00D, 0, rd, er, lat);
      xact(1'b1, 32'h402, 32'h55AA_55AA, 0, rd, er, lat);
      check("err_flag", {31'd0, er}, 32'd1);
      check("err_rdata", rd, 32'd0);
      check("err_latency", 32'(lat), 32'd4);
      xact(1'b1, 32'h3, 32'h77AA_77AA, 0, rd, er, lat);
      check("misalign_err", {31'd0, er}, 32'd1);
      xact(1'b0, 32'h0, 32'd0, 0, rd, er, lat);
      check("err_mem_unchanged", rd, 32'h0BAD_F00D);
      check("ok_no_err", {31'd0, er}, 32'd0);
`else
      xact(1'b1, 32'h404, 32'h600D_CAFE, 0, rd, er, lat);
      check("alias_no_err", {31'd0, er}, 32'd0);
      xact(1'b0, 32'h4, 32'd0, 0, rd, er, lat);
      check("alias_read", rd, 32'h600D_CAFE);
`endif

      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 3) == 0) a = $urandom;
         else a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         xact(1'($urandom), a, $urandom, int'($urandom_range(0, 3)), rd, er, lat);
      end

      u1_req_valid = 1'b1; u1_req_wr = 1'b1; u1_req_addr = 32'h8; u1_req_wdata = 32'hCAFE_F00D;
      u1_resp_ready = 1'b1;
      check("l1_ready", {31'd0, u1_req_ready}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         u1_req_valid = 1'b0;
         n = 0;
         while (!u1_resp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("l1_latency", 32'(n), 32'd1);
         check("l1_data", u1_resp_rdata, 32'hCAFE_F00D);
         @(posedge clk);
         @(negedge clk);
         check("l1_idle", {31'd0, u1_req_ready}, 32'd1);
         check("l1_valid_drop", {31'd0, u1_resp_valid}, 32'd0);
         u1_req_valid = 1'b1; u1_req_wr = 1'b0; u1_req_wdata = 32'd0;
      end
      u1_req_valid = 1'b0;

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
